spfp_subtractor_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing `result = operand1 - operand2`. It complements the combinational single-precision adder. It serialises alignment and normalisation one bit per clock, so a small shifter replaces the barrel shifters. It sits behind a valid/ready request port and a valid/ready result port, and handles one operation at a time.

---
 rtl/spfp_pkg.sv | 21 ++
 rtl/spfp_unpack.sv | 36 +++
 rtl/spfp_subtractor_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spfp_subtractor_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spfp_pkg.sv
// Shared definitions for the sequential single-precision subtractor.
// Holds the FSM state encodings, IEEE-754 field constants, the datapath width
// and the default alignment saturation limit.
package spfp_pkg;

  localparam int unsigned EXP_BIAS      = 127;
  localparam int unsigned EXP_MAX       = 255;
  localparam logic [31:0] QNAN          = 32'h7FC0_0000;
  // carry, hidden, 23 fraction, guard, round, sticky
  localparam int unsigned DP_W          = 28;
  localparam int unsigned ALIGN_MAX_DEF = 26;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StUnpack = 3'd1;
  localparam logic [2:0] StAlign  = 3'd2;
  localparam logic [2:0] StAdd    = 3'd3;
  localparam logic [2:0] StNorm   = 3'd4;
  localparam logic [2:0] StPack   = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

endpackage

// File: rtl/spfp_unpack.sv
// Combinational IEEE-754 single-precision field decoder.
// Ports:
//   op_i      - 32-bit operand
//   sign_o    - sign bit
//   exp_o     - biased exponent (0 when the operand is flushed to zero)
//   mant_o    - 24-bit mantissa including the hidden bit (0 when flushed)
//   is_zero_o - exponent field is 0 (zeros and denormals, flushed to signed zero)
//   is_inf_o  - infinity
//   is_nan_o  - any NaN
module spfp_unpack
  import spfp_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        sign_o,
  output logic [7:0]  exp_o,
  output logic [23:0] mant_o,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o
);

  logic [7:0]  exp_f;
  logic [22:0] frac_f;

  always_comb begin
    exp_f     = op_i[30:23];
    frac_f    = op_i[22:0];
    sign_o    = op_i[31];
    is_zero_o = (exp_f == 8'd0);
    is_inf_o  = (exp_f == 8'(EXP_MAX)) && (frac_f == 23'd0);
    is_nan_o  = (exp_f == 8'(EXP_MAX)) && (frac_f != 23'd0);
    exp_o     = is_zero_o ? 8'd0 : exp_f;
    mant_o    = is_zero_o ? 24'd0 : {1'b1, frac_f};
  end

endmodule

// File: rtl/spfp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: result = operand1 - operand2.
// Alignment and normalisation shift one bit per clock; truncating rounding,
// no denormal support.
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   - request handshake (in_ready high only in IDLE)
//   operand1, operand2    - minuend and subtrahend
//   out_valid / out_ready - result handshake, result held until accepted
//   result                - difference
//   overflow / underflow  - saturated to infinity / nonzero flushed to zero
module spfp_subtractor_seq
  import spfp_pkg::*;
#(
  parameter int unsigned ALIGN_MAX = ALIGN_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [7:0] AlignMax8 = (ALIGN_MAX > 255) ? 8'd255 : 8'(ALIGN_MAX);

  logic [2:0]      state_q, state_d;
  logic [31:0]     op1_q, op1_d, op2_q, op2_d;
  logic [DP_W-1:0] ma_q, ma_d, mb_q, mb_d;
  logic [8:0]      exp_q, exp_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            sign_q, sign_d, sub_q, sub_d;
  logic            special_q, special_d, zero_q, zero_d;
  logic [31:0]     spec_res_q, spec_res_d;
  logic [31:0]     result_q, result_d;
  logic            ovf_q, ovf_d, uf_q, uf_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  // Operand 2 with its sign flipped turns the subtraction into a signed add.
  logic [31:0] op2n;
  assign op2n = {~op2_q[31], op2_q[30:0]};

  logic        s1, s2, z1, z2, i1, i2, n1, n2;
  logic [7:0]  e1, e2;
  logic [23:0] m1, m2;

  spfp_unpack u_unpack_a (
    .op_i      (op1_q),
    .sign_o    (s1),
    .exp_o     (e1),
    .mant_o    (m1),
    .is_zero_o (z1),
    .is_inf_o  (i1),
    .is_nan_o  (n1)
  );

  spfp_unpack u_unpack_b (
    .op_i      (op2n),
    .sign_o    (s2),
    .exp_o     (e2),
    .mant_o    (m2),
    .is_zero_o (z2),
    .is_inf_o  (i2),
    .is_nan_o  (n2)
  );

  // Operand ordering, alignment distance and special-case result
  logic            swap, sa, sb, special;
  logic [7:0]      ea, eb, d_raw, d_sat;
  logic [23:0]     mant_a, mant_b;
  logic [31:0]     spec_res;
  logic [DP_W-1:0] sum;

  always_comb begin
    // Ties keep operand1 as A so A - B is never negative.
    swap   = (op2_q[30:0] > op1_q[30:0]);
    sa     = swap ? s2 : s1;
    sb     = swap ? s1 : s2;
    ea     = swap ? e2 : e1;
    eb     = swap ? e1 : e2;
    mant_a = swap ? m2 : m1;
    mant_b = swap ? m1 : m2;
    d_raw  = ea - eb;
    d_sat  = (d_raw > AlignMax8) ? AlignMax8 : d_raw;

    special = n1 | n2 | i1 | i2 | z1 | z2;
    if (n1 || n2) begin
      spec_res = QNAN;
    end else if (i1 && i2 && (op1_q[31] == op2_q[31])) begin
      spec_res = QNAN;
    end else if (i1) begin
      spec_res = op1_q;
    end else if (i2) begin
      spec_res = op2n;
    end else if (z1 && z2) begin
      spec_res = 32'd0;
    end else if (z1) begin
      spec_res = op2n;
    end else begin
      spec_res = op1_q;
    end

    sum = sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
  end

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    special_d  = special_q;
    zero_d     = zero_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    uf_d       = uf_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op1_d   = operand1;
          op2_d   = operand2;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        sign_d     = sa;
        exp_d      = {1'b0, ea};
        ma_d       = {1'b0, mant_a, 3'b000};
        mb_d       = {1'b0, mant_b, 3'b000};
        sub_d      = sa ^ sb;
        cnt_d      = d_sat;
        special_d  = special;
        spec_res_d = spec_res;
        zero_d     = 1'b0;
        if (special) begin
          state_d = StPack;
        end else if (d_sat != 8'd0) begin
          state_d = StAlign;
        end else begin
          state_d = StAdd;
        end
      end
      StAlign: begin
        // Bit falling off the bottom is folded into sticky.
        mb_d  = {1'b0, mb_q[DP_W-1:2], mb_q[1] | mb_q[0]};
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        ma_d = sum;
        if (sum == '0) begin
          zero_d  = 1'b1;
          state_d = StPack;
        end else if (sum[27] || !sum[26]) begin
          state_d = StNorm;
        end else begin
          state_d = StPack;
        end
      end
      StNorm: begin
        if (ma_q[27]) begin
          ma_d    = {1'b0, ma_q[DP_W-1:2], ma_q[1] | ma_q[0]};
          exp_d   = exp_q + 9'd1;
          state_d = StPack;
        end else begin
          ma_d  = {ma_q[DP_W-2:0], 1'b0};
          exp_d = exp_q - 9'd1;
          // Exponent hitting 0 stops normalisation; PACK flushes it.
          if (exp_q == 9'd1 || ma_q[25]) begin
            state_d = StPack;
          end
        end
      end
      StPack: begin
        ovf_d = 1'b0;
        uf_d  = 1'b0;
        if (special_q) begin
          result_d = spec_res_q;
        end else if (zero_q) begin
          result_d = 32'd0;
        end else if (exp_q == 9'd0) begin
          result_d = {sign_q, 31'd0};
          uf_d     = 1'b1;
        end else if (exp_q >= 9'(EXP_MAX)) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[7:0], ma_q[25:3]};
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      special_q   <= 1'b0;
      zero_q      <= 1'b0;
      spec_res_q  <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      uf_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      special_q   <= special_d;
      zero_q      <= zero_d;
      spec_res_q  <= spec_res_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      uf_q        <= uf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_spfp_subtractor_seq.sv
// Directed bench for spfp_subtractor_seq with a result scoreboard.
module tb_spfp_subtractor_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        uf;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  spfp_subtractor_seq #(
    .ALIGN_MAX (26)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Drive one request; the accept edge is the posedge inside this task.
  task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                          input logic eo, input logic eu, input int lat, input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    e.res = r; e.ovf = eo; e.uf = eu; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard head,
  // then optionally complete the result handshake.
  task automatic collect(input bit accept);
    exp_t e;
    int   lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("out_valid timeout", {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({e.tag, " result"}, result, e.res);
      chk({e.tag, " overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
      chk({e.tag, " underflow"}, {31'd0, underflow}, {31'd0, e.uf});
    end
    if (accept) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("post-accept out_valid", {31'd0, out_valid}, 32'd0);
      chk("post-accept in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    exp_t        dropped;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand1  = '0;
    operand2  = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // out_ready high before any result must not disturb anything
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("early out_ready out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    push_req(32'h41A0_0000, 32'h4120_0000, 32'h4120_0000, 1'b0, 1'b0, 5, "20-10");
    collect(1'b1);
    push_req(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 3, "1-1");
    collect(1'b1);
    push_req(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0, 4, "1+1 carry");
    collect(1'b1);
    push_req(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2, "inf-inf");
    collect(1'b1);
    push_req(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 2, "inf-1");
    collect(1'b1);
    push_req(32'hFFC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2, "nan-1");
    collect(1'b1);
    push_req(32'h0000_0000, 32'h4040_0000, 32'hC040_0000, 1'b0, 1'b0, 2, "0-3");
    collect(1'b1);
    push_req(32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b0, 2, "denorm flush");
    collect(1'b1);
    push_req(32'h4120_0000, 32'h41A0_0000, 32'hC120_0000, 1'b0, 1'b0, 5, "10-20 swap");
    collect(1'b1);
    push_req(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 4, "overflow");
    collect(1'b1);
    push_req(32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 4, "underflow");
    collect(1'b1);
    push_req(32'h4B80_0000, 32'h0080_0000, 32'h4B7F_FFFF, 1'b0, 1'b0, 30, "align sat");
    collect(1'b1);

    // Back-pressure: result held, in_ready low, stray in_valid ignored
    push_req(32'h41A0_0000, 32'h4120_0000, 32'h4120_0000, 1'b0, 1'b0, 5, "hold");
    collect(1'b0);
    held = 32'h4120_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3);
      operand1 = 32'h3F80_0000;
      operand2 = 32'hBF80_0000;
      chk("hold result", result, held);
      chk("hold out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hold release in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("stray request ignored", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back requests
    push_req(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0, 4, "b2b first");
    collect(1'b1);
    push_req(32'h41A0_0000, 32'h4120_0000, 32'h4120_0000, 1'b0, 1'b0, 5, "b2b second");
    collect(1'b1);

    // Reset while aligning
    push_req(32'h4B80_0000, 32'h0080_0000, 32'h4B7F_FFFF, 1'b0, 1'b0, 30, "reset mid");
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    dropped = sb.pop_front();
    @(negedge clk);
    reset = 1'b0;
    push_req(32'h41A0_0000, 32'h4120_0000, 32'h4120_0000, 1'b0, 1'b0, 5, "after reset");
    collect(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
